// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
// The package keeps the name mem_pkg so existing imports still resolve.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_t;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned CNT_W               = 4;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned LANES               = 4;

  // Replace the byte lanes selected by be with lanes from new_word.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [LANES-1:0]  be
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Initiator/responder bus for mem_responder: request qualifiers in,
// read data and one-cycle completion strobe out.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 7
);
  import mem_pkg::*;

  logic                     re;
  logic [LANES-1:0]         we;
  logic [ADDR_W-1:0]        addr;
  logic [DATA_W-1:0]        din;
  logic [DATA_W-1:0]        dout;
  logic                     dready;

  modport master (
    output re,
    output we,
    output addr,
    output din,
    input  dout,
    input  dready
  );

  modport slave (
    input  re,
    input  we,
    input  addr,
    input  din,
    output dout,
    output dready
  );

endinterface

// File: rtl/mem_responder_bram_be.sv
// Single-port synchronous RAM with per-byte write enables and a
// registered read port (data appears the cycle after the address).
module bram_be
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: latches a request, inserts WAIT_CYCLES wait states,
// then completes it with a one-cycle dready strobe and holds until release.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  state_t             state;
  state_t             state_next;

  logic [CNT_W-1:0]   cnt;
  logic               re_q;
  logic [LANES-1:0]   we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;

  logic               active;
  logic [LANES-1:0]   ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;

  logic               dready_r;
  logic [DATA_W-1:0]  dout_r;

  assign active = bus.re || (bus.we != '0);

  // The RAM read is launched from the live address in IDLE so that the
  // old word is already registered when RESP is reached with zero waits.
  assign ram_addr = (state == IDLE) ? bus.addr : addr_q;
  assign ram_we   = (state == RESP && rst) ? we_q : '0;

  bram_be #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (active) begin
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!active) begin
          state_next = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (!active) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      re_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      dready_r <= 1'b0;
      dout_r   <= '0;
    end else begin
      dready_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (active) begin
            re_q   <= bus.re;
            we_q   <= bus.we;
            addr_q <= bus.addr;
            din_q  <= bus.din;
            cnt    <= CNT_W'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (active) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        RESP: begin
          dready_r <= 1'b1;
          cnt      <= '0;
          // Read data is the post-write word so read+write returns the merge.
          if (re_q) begin
            dout_r <= merge_lanes(ram_rdata, din_q, we_q);
          end
        end
        HOLD: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.dready = dready_r;
  assign bus.dout   = dout_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with two wait states
// and one with none, checked against an array model of memory contents.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(7)) bus0 ();
  mem_responder_if #(.ADDR_W(7)) bus2 ();

  mem_responder #(.ADDR_W(7), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_responder #(.ADDR_W(7), .WAIT_CYCLES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // index 0: zero-wait instance, index 1: two-wait instance
  logic [31:0] model [2][128];
  logic [31:0] last_dout [2];

  function automatic int exp_lat(input int sel);
    return (sel == 1) ? 3 : 1;
  endfunction

  function automatic logic get_dready(input int sel);
    return (sel == 1) ? bus2.dready : bus0.dready;
  endfunction

  function automatic logic [31:0] get_dout(input int sel);
    return (sel == 1) ? bus2.dout : bus0.dout;
  endfunction

  task automatic drive(input int sel, input logic r, input logic [3:0] w,
                       input logic [6:0] a, input logic [31:0] d);
    if (sel == 1) begin
      bus2.re = r; bus2.we = w; bus2.addr = a; bus2.din = d;
    end else begin
      bus0.re = r; bus0.we = w; bus0.addr = a; bus0.din = d;
    end
  endtask

  task automatic model_apply(input int sel, input logic r, input logic [3:0] w,
                             input logic [6:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      if (w[i]) model[sel][a][8*i +: 8] = d[8*i +: 8];
    end
    if (r) last_dout[sel] = model[sel][a];
  endtask

  // Called just after a rising edge. Returns edges from first sample to dready
  // (-1 on timeout), dout seen with dready, and dready one cycle after release.
  task automatic txn(input int sel, input logic r, input logic [3:0] w,
                     input logic [6:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] q, output logic dr_after);
    drive(sel, r, w, a, d);
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (get_dready(sel) === 1'b1) begin
        lat = k;
        break;
      end
    end
    q = get_dout(sel);
    drive(sel, 1'b0, 4'h0, a, d);
    @(posedge clk); #1;
    dr_after = get_dready(sel);
  endtask

  task automatic test_reset();
    drive(0, 1'b0, 4'h0, 7'd0, 32'h0);
    drive(1, 1'b0, 4'h0, 7'd0, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (get_dready(s) !== 1'b0) begin
        n_fail++; $display("FAIL reset_dready sel=%0d got=%b exp=0", s, get_dready(s));
      end
      n_checks++;
      if (get_dout(s) !== 32'h0) begin
        n_fail++; $display("FAIL reset_dout sel=%0d got=%h exp=00000000", s, get_dout(s));
      end
      last_dout[s] = 32'h0;
    end
    n_checks++;
    if (dut2.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dut2.state, IDLE);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int lat; logic [31:0] q; logic dr; logic [31:0] d;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 128; a++) begin
        d = $urandom;
        txn(s, 1'b0, 4'hF, 7'(a), d, lat, q, dr);
        model_apply(s, 1'b0, 4'hF, 7'(a), d);
        n_checks++;
        if (lat !== exp_lat(s) || q !== last_dout[s] || dr !== 1'b0) begin
          n_fail++;
          $display("FAIL fill sel=%0d addr=%0d lat=%0d exp=%0d dout=%h exp=%h after=%b",
                   s, a, lat, exp_lat(s), q, last_dout[s], dr);
        end
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] q; logic dr;
    txn(1, 1'b0, 4'hF, 7'd5, 32'hDEADBEEF, lat, q, dr);
    model_apply(1, 1'b0, 4'hF, 7'd5, 32'hDEADBEEF);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    txn(1, 1'b1, 4'h0, 7'd5, 32'h0, lat, q, dr);
    model_apply(1, 1'b1, 4'h0, 7'd5, 32'h0);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    n_checks++;
    if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", q); end
    n_checks++;
    if (dr !== 1'b0) begin n_fail++; $display("FAIL rd_single_pulse got=%b exp=0", dr); end
  endtask

  task automatic test_partial();
    int lat; logic [31:0] q; logic dr;
    txn(1, 1'b0, 4'hF, 7'd7, 32'h11223344, lat, q, dr);
    model_apply(1, 1'b0, 4'hF, 7'd7, 32'h11223344);
    txn(1, 1'b0, 4'b0101, 7'd7, 32'hAABBCCDD, lat, q, dr);
    model_apply(1, 1'b0, 4'b0101, 7'd7, 32'hAABBCCDD);
    n_checks++;
    if (q !== last_dout[1]) begin
      n_fail++; $display("FAIL write_keeps_dout got=%h exp=%h", q, last_dout[1]);
    end
    txn(1, 1'b1, 4'h0, 7'd7, 32'h0, lat, q, dr);
    model_apply(1, 1'b1, 4'h0, 7'd7, 32'h0);
    n_checks++;
    if (q !== 32'h11BB33DD) begin n_fail++; $display("FAIL partial_write got=%h exp=11bb33dd", q); end
  endtask

  task automatic test_held();
    int pulses;
    drive(1, 1'b1, 4'h0, 7'd3, 32'h0);
    pulses = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus2.dready === 1'b1) pulses++;
    end
    model_apply(1, 1'b1, 4'h0, 7'd3, 32'h0);
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    n_checks++;
    if (bus2.dout !== last_dout[1]) begin
      n_fail++; $display("FAIL held_dout got=%h exp=%h", bus2.dout, last_dout[1]);
    end
    drive(1, 1'b0, 4'h0, 7'd3, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (bus2.dready !== 1'b0) begin n_fail++; $display("FAIL held_release got=%b exp=0", bus2.dready); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] q; logic dr; int pulses;
    drive(1, 1'b0, 4'hF, 7'd9, ~model[1][9]);
    @(posedge clk); #1;
    drive(1, 1'b0, 4'h0, 7'd9, 32'h0);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus2.dready !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_dready got=%0d exp=0", pulses); end
    n_checks++;
    if (bus2.dout !== last_dout[1]) begin
      n_fail++; $display("FAIL abort_dout got=%h exp=%h", bus2.dout, last_dout[1]);
    end
    txn(1, 1'b1, 4'h0, 7'd9, 32'h0, lat, q, dr);
    model_apply(1, 1'b1, 4'h0, 7'd9, 32'h0);
    n_checks++;
    if (q !== last_dout[1] || lat !== 3) begin
      n_fail++; $display("FAIL abort_word got=%h exp=%h lat=%0d", q, last_dout[1], lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] q; logic dr; logic [31:0] v;
    v = $urandom;
    txn(1, 1'b0, 4'hF, 7'd20, v, lat, q, dr);
    model_apply(1, 1'b0, 4'hF, 7'd20, v);
    // reset lands while the two-wait instance is in WAIT
    drive(1, 1'b0, 4'hF, 7'd20, ~v);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1'b0, 4'h0, 7'd20, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (bus2.dready !== 1'b0 || bus2.dout !== 32'h0) begin
      n_fail++; $display("FAIL reset_wait_outputs dready=%b dout=%h exp=0/00000000", bus2.dready, bus2.dout);
    end
    n_checks++;
    if (dut2.state !== IDLE) begin n_fail++; $display("FAIL reset_wait_state got=%0d exp=%0d", dut2.state, IDLE); end
    last_dout[0] = 32'h0; last_dout[1] = 32'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b1, 4'h0, 7'd20, 32'h0, lat, q, dr);
    model_apply(1, 1'b1, 4'h0, 7'd20, 32'h0);
    n_checks++;
    if (q !== v) begin n_fail++; $display("FAIL reset_keeps_mem got=%h exp=%h", q, v); end
    // reset lands while the zero-wait instance is in RESP
    drive(0, 1'b0, 4'hF, 7'd21, ~model[0][21]);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 4'h0, 7'd21, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if (bus0.dready !== 1'b0) begin n_fail++; $display("FAIL reset_resp_dready got=%b exp=0", bus0.dready); end
    last_dout[0] = 32'h0; last_dout[1] = 32'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    txn(0, 1'b1, 4'h0, 7'd21, 32'h0, lat, q, dr);
    model_apply(0, 1'b1, 4'h0, 7'd21, 32'h0);
    n_checks++;
    if (q !== last_dout[0]) begin n_fail++; $display("FAIL reset_resp_no_write got=%h exp=%h", q, last_dout[0]); end
  endtask

  task automatic test_zero_wait_wrap();
    int lat; logic [31:0] q; logic dr; logic [31:0] v;
    txn(0, 1'b1, 4'h0, 7'd4, 32'h0, lat, q, dr);
    model_apply(0, 1'b1, 4'h0, 7'd4, 32'h0);
    n_checks++;
    if (lat !== 1 || q !== last_dout[0]) begin
      n_fail++; $display("FAIL zero_wait_read lat=%0d exp=1 dout=%h exp=%h", lat, q, last_dout[0]);
    end
    v = $urandom;
    txn(0, 1'b0, 4'hF, 7'd127, v, lat, q, dr);
    model_apply(0, 1'b0, 4'hF, 7'd127, v);
    txn(0, 1'b1, 4'h0, 7'd127, 32'h0, lat, q, dr);
    model_apply(0, 1'b1, 4'h0, 7'd127, 32'h0);
    n_checks++;
    if (q !== v || lat !== 1) begin n_fail++; $display("FAIL wrap_top_word got=%h exp=%h lat=%0d", q, v, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] q; logic dr; logic r; logic [3:0] w; logic [6:0] a; logic [31:0] d;
    for (int s = 0; s < 2; s++) begin
      repeat (60) begin
        r = 1'($urandom_range(0, 1));
        w = 4'($urandom);
        if (!r && w == 4'h0) r = 1'b1;
        a = 7'($urandom);
        d = $urandom;
        txn(s, r, w, a, d, lat, q, dr);
        model_apply(s, r, w, a, d);
        n_checks++;
        if (lat !== exp_lat(s) || q !== last_dout[s] || dr !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b sel=%0d re=%b we=%h addr=%0d lat=%0d exp=%0d dout=%h exp=%h after=%b",
                   s, r, w, a, lat, exp_lat(s), q, last_dout[s], dr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_partial();
    test_held();
    test_abort();
    test_reset_mid();
    test_zero_wait_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the word-address width (depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states (0..15) inserted before dready.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port re, input, 1 bit: read request from the initiator.
REQ-006 SHALL have port we, input, 4 bits: byte write enables; we[i] writes byte lane i (bits 8i+7:8i).
REQ-007 SHALL have port addr, input, ADDR_W bits: word address.
REQ-008 SHALL have port din, input, 32 bits: write data.
REQ-009 SHALL have port dout, output, 32 bits: read data.
REQ-010 SHALL have port dready, output, 1 bit: one-cycle completion strobe.

Function
REQ-011 SHALL treat a request as active when re=1 or we!=0; the initiator holds re, we, addr and din stable until it samples dready=1.
REQ-012 SHALL implement states IDLE, WAIT, RESP and HOLD.
REQ-013 SHALL, in IDLE with an active request, latch re, we, addr and din, and load the wait counter with WAIT_CYCLES.
- Next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-014 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the cycle the counter reaches 0.
- dready is asserted exactly WAIT_CYCLES+1 cycles after the request is first sampled.
REQ-015 SHALL, in RESP, assert dready for exactly one cycle, perform any latched write, and update dout with any latched read, all on the same edge.
REQ-016 SHALL, in HOLD, keep dready=0 and return to IDLE only on a cycle with re=0 and we=0, so one held request completes exactly once.
REQ-017 SHALL write only the byte lanes whose we bit is set; other lanes keep their contents.
REQ-018 SHALL, when re=1 and we!=0 together, perform the write and return the merged post-write word on dout.
REQ-019 SHALL, if the request drops (re=0 and we=0) during WAIT, abort to IDLE with no write, no dready and dout unchanged.
REQ-020 SHALL hold dout at the last read value between reads; write-only transactions leave dout unchanged.
REQ-021 SHALL wrap addresses modulo 2^ADDR_W; there is no out-of-range error.
REQ-022 SHALL, with back-to-back requests (deassert for one cycle, then reassert), accept the new request from IDLE with the same latency.

Reset
REQ-023 SHALL, when rst=0 at a rising edge, set the state to IDLE, dready to 0, dout to 32'h0000_0000 and the counter to 0.
REQ-024 SHALL NOT clear memory contents on reset.
REQ-025 SHALL, on reset during WAIT or RESP, drop the transaction with no write, even if it would have completed on that edge.

Structure
REQ-026 SHALL take the state enumeration, the default WAIT_CYCLES and the 4-bit counter width from the shared package mem_pkg.
REQ-027 SHALL instantiate one sub-module, bram_be: a synchronous 32-bit RAM with 4-bit byte enables, a single port and one-cycle read.
- The FSM, counter and output registers stay in mem_responder.

Verification
REQ-028 SHALL cover a write then read (WAIT_CYCLES=2):
- we=4'hF, addr=5, din=32'hDEADBEEF: dready high 3 cycles after the request.
- Then re=1, addr=5: dout=32'hDEADBEEF when dready=1.
REQ-029 SHALL cover a partial write:
- Word 7 preloaded 32'h11223344, then we=4'b0101, din=32'hAABBCCDD.
- A read of word 7 returns 32'h11BB33DD.
REQ-030 SHALL cover a held request:
- re held 10 cycles at addr=3: dready pulses exactly once, then stays 0 until re drops.
REQ-031 SHALL cover an abort:
- Write to addr=9 dropped after 1 cycle (WAIT_CYCLES=2): no dready, and word 9 is unchanged on a later read.
REQ-032 SHALL cover reset mid-operation:
- rst=0 in WAIT: next cycle dready=0, dout=0, state IDLE.
- Memory written before the reset still reads back its value.
REQ-033 SHALL cover zero wait states and wrap-around (WAIT_CYCLES=0):
- A read gives dready on the next cycle.
- A write to addr=127 followed by a read of addr=127 returns the written data.
